// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin, burst-capped sharing of one pixel write
// port between N_REQ producers, opened by frame_start and closed once all report done.

module fb_wr_lane (
   input  logic clk_33m,
   input  logic rst_n,
   input  logic clr,
   input  logic busy,
   input  logic req_done,
   input  logic req_valid,
   input  logic granted,
   output logic done_eff,
   output logic ready
);
   logic done_lat;

   always_ff @(posedge clk_33m) begin
      if (!rst_n)                done_lat <= 1'b0;
      else if (clr)              done_lat <= 1'b0;
      else if (busy && req_done) done_lat <= 1'b1;
   end

   // Arbitration sees a done raised this cycle; the ready path only sees the latch, so a
   // transfer that coincides with req_done is still taken.
   assign done_eff = done_lat | (busy & req_done);
   assign ready    = granted & req_valid & ~done_lat;
endmodule

module fb_write_arbiter #(
   parameter int N_REQ   = 2,
   parameter int COORD_W = 12,
   parameter int PAL_W   = 2,
   parameter int BURST   = 16
) (
   input  logic                            clk_33m,
   input  logic                            rst_n,
   input  logic                            frame_start,
   input  logic [N_REQ-1:0]                req_valid,
   input  logic [N_REQ-1:0][COORD_W-1:0]   req_x,
   input  logic [N_REQ-1:0][COORD_W-1:0]   req_y,
   input  logic [N_REQ-1:0][PAL_W-1:0]     req_pal,
   input  logic [N_REQ-1:0]                req_done,
   output logic [N_REQ-1:0]                req_ready,
   output logic [COORD_W-1:0]              write_x,
   output logic [COORD_W-1:0]              write_y,
   output logic [PAL_W-1:0]                write_palette,
   output logic                            write_en,
   output logic                            frame_busy,
   output logic                            frame_done
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(BURST + 1);

   typedef enum logic [1:0] {IDLE, ARB, GRANT, DONE} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr, gnt, sel;
   logic [CNT_W-1:0]   burst_cnt;
   logic [N_REQ-1:0]   done_eff, granted, elig;
   logic               found, all_done, xfer, last, leave, lane_clr;

   assign lane_clr = (state == IDLE) || frame_start;

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      fb_wr_lane u_lane (
         .clk_33m   (clk_33m),
         .rst_n     (rst_n),
         .clr       (lane_clr),
         .busy      (frame_busy),
         .req_done  (req_done[i]),
         .req_valid (req_valid[i]),
         .granted   (granted[i]),
         .done_eff  (done_eff[i]),
         .ready     (req_ready[i])
      );
   end

   assign elig     = req_valid & ~done_eff;
   assign all_done = &done_eff;
   assign xfer     = |req_ready;
   assign last     = xfer && (burst_cnt == CNT_W'(BURST - 1));
   assign leave    = !req_valid[gnt] || req_done[gnt] || last;

   // Lowest eligible index at or above rr wins; otherwise wrap to the lowest overall.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (elig[i]) begin
            sel   = IDX_W'(i);
            found = 1'b1;
         end
      for (int i = N_REQ - 1; i >= 0; i--)
         if (elig[i] && (IDX_W'(i) >= rr)) sel = IDX_W'(i);
   end

   always_ff @(posedge clk_33m) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = ARB;
         ARB:     if (frame_start)   state_nxt = ARB;
                  else if (all_done) state_nxt = DONE;
                  else if (found)    state_nxt = GRANT;
         GRANT:   if (frame_start || leave) state_nxt = ARB;
         DONE:    state_nxt = frame_start ? ARB : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      granted = '0;
      if (state == GRANT && !frame_start) granted[gnt] = 1'b1;
      frame_busy = (state == ARB) || (state == GRANT);
      frame_done = (state == DONE);
   end

   // An abort leaves rr alone so the interrupted owner keeps its turn.
   always_ff @(posedge clk_33m) begin
      if (!rst_n) begin
         rr        <= '0;
         gnt       <= '0;
         burst_cnt <= '0;
      end else if (!frame_start) begin
         if (state == ARB && found && !all_done) begin
            gnt       <= sel;
            burst_cnt <= '0;
         end
         if (state == GRANT) begin
            if (xfer)  burst_cnt <= burst_cnt + 1'b1;
            if (leave) rr <= (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_33m) begin
      if (!rst_n || !xfer) begin
         write_en      <= 1'b0;
         write_x       <= '1;
         write_y       <= '1;
         write_palette <= '0;
      end else begin
         write_en      <= 1'b1;
         write_x       <= req_x[gnt];
         write_y       <= req_y[gnt];
         write_palette <= req_pal[gnt];
      end
   end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scenario bench for fb_write_arbiter: producer BFMs, write-port scoreboard and
// per-cycle ready/busy/done expectations for N_REQ=2, BURST=16.

module tb_fb_write_arbiter;
   localparam int N_REQ   = 2;
   localparam int COORD_W = 12;
   localparam int PAL_W   = 2;
   localparam int BURST   = 16;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [PAL_W-1:0]   pal;
   } pix_t;

   logic                          clk_33m = 1'b0;
   logic                          rst_n = 1'b0;
   logic                          frame_start = 1'b0;
   logic [N_REQ-1:0]              req_valid = '0;
   logic [N_REQ-1:0][COORD_W-1:0] req_x = '0;
   logic [N_REQ-1:0][COORD_W-1:0] req_y = '0;
   logic [N_REQ-1:0][PAL_W-1:0]   req_pal = '0;
   logic [N_REQ-1:0]              req_done = '0;
   logic [N_REQ-1:0]              req_ready;
   logic [COORD_W-1:0]            write_x, write_y;
   logic [PAL_W-1:0]              write_palette;
   logic                          write_en, frame_busy, frame_done;

   logic [N_REQ-1:0] valid_en = '0;
   int               idx [N_REQ];
   logic             exp_we = 1'b0;
   logic             obs_fd;
   pix_t             sb [$];
   int               n_chk = 0;
   int               n_pass = 0;

   fb_write_arbiter #(.N_REQ(N_REQ), .COORD_W(COORD_W), .PAL_W(PAL_W), .BURST(BURST)) dut (
      .clk_33m(clk_33m), .rst_n(rst_n), .frame_start(frame_start),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_pal(req_pal),
      .req_done(req_done), .req_ready(req_ready),
      .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
      .write_en(write_en), .frame_busy(frame_busy), .frame_done(frame_done)
   );

   always #5 clk_33m = ~clk_33m;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic pix_t pix(input int i, input int n);
      pix_t p;
      p.x   = COORD_W'(i * 1000 + n * 7 + 1);
      p.y   = COORD_W'(3000 - i * 500 - n * 3);
      p.pal = PAL_W'(n + i);
      return p;
   endfunction

   task automatic drive;
      pix_t p;
      for (int i = 0; i < N_REQ; i++) begin
         p          = pix(i, idx[i]);
         req_x[i]   = p.x;
         req_y[i]   = p.y;
         req_pal[i] = p.pal;
      end
      req_valid = valid_en;
   endtask

   // One clock: check at negedge, record accepted pixels, advance producers after posedge.
   task automatic cycle(input logic [1:0] exp_rdy, input logic exp_busy, input logic exp_fd,
                        input bit chk);
      pix_t e;
      logic [1:0] acc;
      @(negedge clk_33m);
      obs_fd = frame_done;
      n_chk++;
      if (write_en !== exp_we) $display("FAIL write_en: got %b want %b", write_en, exp_we);
      else n_pass++;
      if (write_en === 1'b1) begin
         n_chk++;
         if (sb.size() == 0) $display("FAIL write_data: got unexpected pixel %h/%h", write_x, write_y);
         else begin
            e = sb.pop_front();
            if ({write_x, write_y, write_palette} !== e)
               $display("FAIL write_data: got %h/%h/%h want %h/%h/%h",
                        write_x, write_y, write_palette, e.x, e.y, e.pal);
            else n_pass++;
         end
      end else if (chk) begin
         n_chk++;
         if (write_x !== 12'hFFF || write_y !== 12'hFFF)
            $display("FAIL sentinel: got %h/%h want fff/fff", write_x, write_y);
         else n_pass++;
      end
      if (chk) begin
         n_chk++;
         if (req_ready !== exp_rdy) $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
         else n_pass++;
         n_chk++;
         if (frame_busy !== exp_busy) $display("FAIL frame_busy: got %b want %b", frame_busy, exp_busy);
         else n_pass++;
         n_chk++;
         if (frame_done !== exp_fd) $display("FAIL frame_done: got %b want %b", frame_done, exp_fd);
         else n_pass++;
      end
      acc = rst_n ? (req_ready & req_valid) : 2'b00;
      for (int i = 0; i < N_REQ; i++) if (acc[i] === 1'b1) sb.push_back(pix(i, idx[i]));
      @(posedge clk_33m);
      exp_we = |acc;
      #1;
      for (int i = 0; i < N_REQ; i++) if (acc[i] === 1'b1) idx[i]++;
      drive();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      sb.delete();
      for (int i = 0; i < N_REQ; i++) idx[i] = 0;
      for (int k = 0; k < 3; k++) begin
         valid_en    = 2'($urandom);
         req_done    = 2'($urandom);
         frame_start = (k == 2) ? 1'b1 : 1'($urandom);
         drive();
         cycle(2'b00, 1'b0, 1'b0, k != 0);
      end
      rst_n = 1'b1; frame_start = 1'b0; valid_en = '0; req_done = '0;
      drive();
      // frame_start was coincident with reset, so the block must still be idle
      cycle(2'b00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic finish_frame;
      int pulses;
      pulses   = 0;
      valid_en = '0;
      req_done = 2'b11;
      drive();
      for (int k = 0; k < 8; k++) begin
         cycle(2'b00, 1'b0, 1'b0, 1'b0);
         if (obs_fd === 1'b1) pulses++;
      end
      n_chk++;
      if (pulses != 1) $display("FAIL frame_done_pulses: got %0d want 1", pulses);
      else n_pass++;
      n_chk++;
      if (frame_busy !== 1'b0) $display("FAIL idle_after_done: got busy %b want 0", frame_busy);
      else n_pass++;
      n_chk++;
      if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      else n_pass++;
      req_done = '0;
      drive();
   endtask

   task automatic start_frame(input logic [1:0] v);
      valid_en    = v;
      frame_start = 1'b1;
      drive();
      cycle(2'b00, 1'b0, 1'b0, 1'b1);
      frame_start = 1'b0;
   endtask

   task automatic test_single;
      logic [1:0] exp;
      test_reset();
      start_frame(2'b01);
      for (int t = 0; t < 46; t++) begin
         valid_en[0] = (idx[0] < 40);
         drive();
         exp = (t >= 1 && (t % 17) != 0 && t <= 42) ? 2'b01 : 2'b00;
         cycle(exp, 1'b1, 1'b0, 1'b1);
      end
      n_chk++;
      if (idx[0] != 40) $display("FAIL single_count: got %0d want 40", idx[0]);
      else n_pass++;
      finish_frame();
   endtask

   task automatic test_contention;
      logic [1:0] exp;
      test_reset();
      start_frame(2'b11);
      for (int t = 0; t < 68; t++) begin
         if ((t % 17) == 0)          exp = 2'b00;
         else if (((t / 17) % 2) == 0) exp = 2'b01;
         else                        exp = 2'b10;
         cycle(exp, 1'b1, 1'b0, 1'b1);
      end
      n_chk++;
      if (idx[0] != 32 || idx[1] != 32)
         $display("FAIL contention_count: got %0d/%0d want 32/32", idx[0], idx[1]);
      else n_pass++;
      finish_frame();
   endtask

   task automatic test_done;
      logic [1:0] exp;
      test_reset();
      start_frame(2'b10);
      for (int t = 0; t < 35; t++) begin
         valid_en    = (t >= 3) ? 2'b11 : 2'b10;
         req_done[1] = (t >= 5);
         req_done[0] = (t >= 30);
         drive();
         if (t >= 1 && t <= 5)                           exp = 2'b10;
         else if ((t >= 7 && t <= 22) || (t >= 24 && t <= 30)) exp = 2'b01;
         else                                            exp = 2'b00;
         cycle(exp, t <= 31, t == 32, 1'b1);
      end
      valid_en = '0; req_done = '0;
      drive();
      n_chk++;
      if (sb.size() != 0) $display("FAIL done_drain: got %0d pending want 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_abort;
      logic [1:0] exp;
      test_reset();
      start_frame(2'b01);
      for (int t = 0; t < 33; t++) begin
         valid_en[0] = (t < 3) || (t >= 12);
         valid_en[1] = (t >= 3);
         req_done[0] = (t >= 4) && (t <= 12);
         frame_start = (t == 12);
         drive();
         if (t == 1 || t == 2 || t >= 31)                    exp = 2'b01;
         else if ((t >= 5 && t <= 11) || (t >= 14 && t <= 29)) exp = 2'b10;
         else                                                exp = 2'b00;
         cycle(exp, 1'b1, 1'b0, 1'b1);
      end
      frame_start = 1'b0;
      finish_frame();
   endtask

   task automatic test_empty;
      test_reset();
      valid_en = 2'b11;
      req_done = 2'b11;
      drive();
      cycle(2'b00, 1'b0, 1'b0, 1'b1);
      start_frame(2'b11);
      cycle(2'b00, 1'b1, 1'b0, 1'b1);
      cycle(2'b00, 1'b0, 1'b1, 1'b1);
      cycle(2'b00, 1'b0, 1'b0, 1'b1);
      cycle(2'b00, 1'b0, 1'b0, 1'b1);
      valid_en = '0; req_done = '0;
      drive();
   endtask

   initial begin
      for (int i = 0; i < N_REQ; i++) idx[i] = 0;
      test_reset();
      test_single();
      test_contention();
      test_done();
      test_abort();
      test_empty();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
